// File: rtl/cgra_conf_pkg.sv
// Shared definitions for the CGRA configuration bus: opcodes, field positions
// and the thread-index width helper.
package cgra_conf_pkg;

    localparam logic [3:0] CONF_OP_PC_MAX    = 4'd1;
    localparam logic [3:0] CONF_OP_PC_LOOP   = 4'd2;
    localparam logic [3:0] CONF_OP_MEM_WR    = 4'd3;
    localparam logic [3:0] CONF_OP_THREAD_EN = 4'd4;
    localparam logic [3:0] CONF_OP_RESTART   = 4'd5;

    localparam int CONF_OP_LSB   = 0;
    localparam int CONF_OP_MSB   = 3;
    localparam int CONF_TGT_LSB  = 4;
    localparam int CONF_TGT_MSB  = 15;
    localparam int CONF_THR_LSB  = 16;
    localparam int CONF_THR_MSB  = 23;
    localparam int CONF_ADDR_LSB = 24;
    localparam int CONF_ADDR_MSB = 39;
    localparam int CONF_DATA_LSB = 40;
    localparam int CONF_DATA_MSB = 63;

    // Thread index width, never narrower than one bit.
    function automatic int thread_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/memory.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module memory #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// Enable-gated delay line of DEPTH registers, no reset.
module reg_pipe #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            stage_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/swicth_conf_decoder_mt.sv
// Registers the configuration bus word and turns it into one-cycle write
// strobes plus the thread/address/data fields that go with them.
module swicth_conf_decoder_mt
    import cgra_conf_pkg::*;
#(
    parameter int SWICTH_NUMBER = 0,
    parameter int NUM_THREADS   = 7,
    parameter int CONF_WIDTH    = 2,
    parameter int PC_WIDTH      = 1,
    parameter int TW            = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           conf_bus_in,
    output logic                  pc_max_we,
    output logic                  pc_loop_we,
    output logic                  mem_we,
    output logic                  thread_en_we,
    output logic                  restart,
    output logic [TW-1:0]         thread,
    output logic [PC_WIDTH-1:0]   addr,
    output logic [CONF_WIDTH-1:0] data
);

    logic [3:0]  op;
    logic [11:0] tgt;
    logic [7:0]  thr;
    logic        tgt_hit;
    logic        thr_ok;
    logic        unused_bus;

    assign op         = conf_bus_in[CONF_OP_MSB:CONF_OP_LSB];
    assign tgt        = conf_bus_in[CONF_TGT_MSB:CONF_TGT_LSB];
    assign thr        = conf_bus_in[CONF_THR_MSB:CONF_THR_LSB];
    assign tgt_hit    = (tgt == 12'(SWICTH_NUMBER));
    // Widened compare so NUM_THREADS = 256 does not alias to zero.
    assign thr_ok     = ({1'b0, thr} < 9'(NUM_THREADS));
    assign unused_bus = ^conf_bus_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_max_we    <= 1'b0;
            pc_loop_we   <= 1'b0;
            mem_we       <= 1'b0;
            thread_en_we <= 1'b0;
            restart      <= 1'b0;
            thread       <= '0;
            addr         <= '0;
            data         <= '0;
        end else begin
            pc_max_we    <= tgt_hit && thr_ok && (op == CONF_OP_PC_MAX);
            pc_loop_we   <= tgt_hit && thr_ok && (op == CONF_OP_PC_LOOP);
            mem_we       <= tgt_hit && thr_ok && (op == CONF_OP_MEM_WR);
            thread_en_we <= tgt_hit && thr_ok && (op == CONF_OP_THREAD_EN);
            restart      <= tgt_hit && (op == CONF_OP_RESTART);
            thread       <= thr[TW-1:0];
            addr         <= conf_bus_in[CONF_ADDR_LSB +: PC_WIDTH];
            data         <= conf_bus_in[CONF_DATA_LSB +: CONF_WIDTH];
        end
    end

endmodule

// File: rtl/swicth_conf_control_mt.sv
// Per-switch multithreaded configuration controller: round-robin thread
// counter, per-thread PCs, configuration memory and a STAGE-aligned output pipe.
module swicth_conf_control_mt
    import cgra_conf_pkg::*;
#(
    parameter int SWICTH_NUMBER = 0,
    parameter int STAGE         = 1,
    parameter int NUM_THREADS   = 7,
    parameter int CONF_WIDTH    = 2,
    parameter int PC_WIDTH      = 1,
    localparam int TW           = thread_w(NUM_THREADS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_pc_net,
    input  logic [63:0]           conf_bus_in,
    output logic [CONF_WIDTH-1:0] swicth_conf_out,
    output logic [TW-1:0]         thread_idx_out
);

    localparam int AW         = TW + PC_WIDTH;
    localparam int PIPE_DEPTH = STAGE + 3;

    logic                  dec_pc_max_we;
    logic                  dec_pc_loop_we;
    logic                  dec_mem_we;
    logic                  dec_thread_en_we;
    logic                  dec_restart;
    logic [TW-1:0]         dec_thread;
    logic [PC_WIDTH-1:0]   dec_addr;
    logic [CONF_WIDTH-1:0] dec_data;

    logic [TW-1:0]         thread_idx;
    logic [PC_WIDTH-1:0]   pc      [NUM_THREADS];
    logic [PC_WIDTH-1:0]   pc_max  [NUM_THREADS];
    logic [PC_WIDTH-1:0]   pc_loop [NUM_THREADS];
    logic [NUM_THREADS-1:0] active;
    logic [PC_WIDTH-1:0]   cur_pc;
    logic [PC_WIDTH-1:0]   next_pc;

    logic [CONF_WIDTH-1:0] rd_data_p0;
    logic                  act_p0;
    logic [CONF_WIDTH-1:0] conf_p0;

    swicth_conf_decoder_mt #(
        .SWICTH_NUMBER (SWICTH_NUMBER),
        .NUM_THREADS   (NUM_THREADS),
        .CONF_WIDTH    (CONF_WIDTH),
        .PC_WIDTH      (PC_WIDTH),
        .TW            (TW)
    ) u_decoder (
        .clk          (clk),
        .rst          (rst),
        .conf_bus_in  (conf_bus_in),
        .pc_max_we    (dec_pc_max_we),
        .pc_loop_we   (dec_pc_loop_we),
        .mem_we       (dec_mem_we),
        .thread_en_we (dec_thread_en_we),
        .restart      (dec_restart),
        .thread       (dec_thread),
        .addr         (dec_addr),
        .data         (dec_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thread_idx <= '0;
        end else if (dec_restart) begin
            thread_idx <= '0;
        end else if (en_pc_net) begin
            thread_idx <= (thread_idx == TW'(NUM_THREADS - 1)) ? '0 : thread_idx + TW'(1);
        end
    end

    // Loop-back happens at pc_max; a loop point above pc_max simply wraps through zero.
    assign cur_pc  = pc[thread_idx];
    assign next_pc = (cur_pc == pc_max[thread_idx]) ? pc_loop[thread_idx] : cur_pc + PC_WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc[t]      <= '0;
                pc_max[t]  <= '0;
                pc_loop[t] <= '0;
            end
            active <= '0;
        end else begin
            if (dec_restart) begin
                for (int t = 0; t < NUM_THREADS; t++) begin
                    pc[t] <= '0;
                end
            end else if (en_pc_net && active[thread_idx]) begin
                pc[thread_idx] <= next_pc;
            end
            if (dec_pc_max_we) begin
                pc_max[dec_thread] <= dec_addr;
            end
            if (dec_pc_loop_we) begin
                pc_loop[dec_thread] <= dec_addr;
            end
            if (dec_thread_en_we) begin
                active[dec_thread] <= dec_data[0];
            end
        end
    end

    // Stage p0: memory read and the matching active flag.
    memory #(
        .ADDR_W (AW),
        .DATA_W (CONF_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (dec_mem_we),
        .waddr ({dec_thread, dec_addr}),
        .wdata (dec_data),
        .re    (en_pc_net),
        .raddr ({thread_idx, cur_pc}),
        .rdata (rd_data_p0)
    );

    always_ff @(posedge clk) begin
        if (en_pc_net) begin
            act_p0 <= active[thread_idx];
        end
    end

    assign conf_p0 = act_p0 ? rd_data_p0 : '0;

    // Stages p1..: delay to line up with the switch's pipeline stage.
    reg_pipe #(
        .DEPTH  (PIPE_DEPTH),
        .DATA_W (CONF_WIDTH)
    ) u_pipe (
        .clk (clk),
        .en  (en_pc_net),
        .d   (conf_p0),
        .q   (swicth_conf_out)
    );

    assign thread_idx_out = thread_idx;

endmodule

// File: tb/tb_swicth_conf_control_mt.sv
// Scoreboard bench: a behavioural model predicts each slot's output when the
// read is issued; predictions are popped when they reach the output pipe.
module tb_swicth_conf_control_mt;

    localparam int SW    = 5;
    localparam int STG   = 1;
    localparam int NT    = 7;
    localparam int CW    = 2;
    localparam int PW    = 2;
    localparam int TW    = 3;
    localparam int DEPTH = STG + 4;
    localparam int PCN   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_pc_net;
    logic [63:0]   conf_bus_in;
    logic [CW-1:0] swicth_conf_out;
    logic [TW-1:0] thread_idx_out;

    always #5 clk = ~clk;

    swicth_conf_control_mt #(
        .SWICTH_NUMBER (SW),
        .STAGE         (STG),
        .NUM_THREADS   (NT),
        .CONF_WIDTH    (CW),
        .PC_WIDTH      (PW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en_pc_net       (en_pc_net),
        .conf_bus_in     (conf_bus_in),
        .swicth_conf_out (swicth_conf_out),
        .thread_idx_out  (thread_idx_out)
    );

    int errors = 0;
    int checks = 0;

    int          m_tidx;
    int          m_pc   [NT];
    int          m_max  [NT];
    int          m_loop [NT];
    bit          m_act  [NT];
    int          m_mem  [NT][PCN];
    logic [63:0] pend;

    typedef struct {
        int thr;
        int val;
    } exp_t;

    exp_t sbq[$];
    int   obs0[$];
    int   obs2[$];
    bit   record;
    bit   have_last;
    int   last_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bw(input int op, input int tgt, input int thr,
                                       input int addr, input int data);
        return {24'(data), 16'(addr), 8'(thr), 12'(tgt), 4'(op)};
    endfunction

    function automatic int mem_init(input int t, input int a);
        int tab2 [PCN] = '{1, 3, 0, 2};
        if (t == 0) return a;
        if (t == 2) return tab2[a];
        return (t + a) % PCN;
    endfunction

    task automatic model_apply(input logic [63:0] w);
        int op, tgt, thr, a, d;
        op  = int'(w[3:0]);
        tgt = int'(w[15:4]);
        thr = int'(w[23:16]);
        a   = int'(w[39:24]) % PCN;
        d   = int'(w[63:40]) % PCN;
        if (tgt != SW) return;
        if (op == 5) begin
            m_tidx = 0;
            for (int t = 0; t < NT; t++) m_pc[t] = 0;
            return;
        end
        if (thr >= NT) return;
        case (op)
            1: m_max[thr]    = a;
            2: m_loop[thr]   = a;
            3: m_mem[thr][a] = d;
            4: m_act[thr]    = w[40];
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_tidx = 0;
        for (int t = 0; t < NT; t++) begin
            m_pc[t] = 0; m_max[t] = 0; m_loop[t] = 0; m_act[t] = 1'b0;
        end
        pend = '0;
        sbq.delete();
        have_last = 1'b0;
    endtask

    task automatic tick(input logic [63:0] w, input bit en);
        exp_t e;
        conf_bus_in = w;
        en_pc_net   = en;
        @(posedge clk);
        if (en) begin
            e.thr = m_tidx;
            e.val = m_act[m_tidx] ? m_mem[m_tidx][m_pc[m_tidx]] : 0;
            sbq.push_back(e);
            if (m_act[m_tidx])
                m_pc[m_tidx] = (m_pc[m_tidx] == m_max[m_tidx]) ? m_loop[m_tidx]
                                                               : (m_pc[m_tidx] + 1) % PCN;
            m_tidx = (m_tidx + 1) % NT;
        end
        model_apply(pend);
        pend = w;
        #1;
        chk("thread_idx", thread_idx_out, m_tidx);
        if (en && sbq.size() == DEPTH) begin
            e = sbq.pop_front();
            chk($sformatf("out_t%0d", e.thr), swicth_conf_out, e.val);
            last_exp  = e.val;
            have_last = 1'b1;
            if (record && e.thr == 0) obs0.push_back(int'(swicth_conf_out));
            if (record && e.thr == 2) obs2.push_back(int'(swicth_conf_out));
        end else if (!en && have_last) begin
            chk("hold_out", swicth_conf_out, last_exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick('0, 1'b1);
    endtask

    task automatic do_reset();
        en_pc_net   = 1'b0;
        conf_bus_in = '0;
        rst = 1'b0;
        #1;
        chk("rst_idx_async", thread_idx_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_idx", thread_idx_out, 0);
        model_reset();
    endtask

    task automatic enable_all();
        for (int t = 0; t < NT; t++) tick(bw(4, SW, t, 0, 1), 1'b0);
        tick('0, 1'b0);
    endtask

    initial begin
        int tgt_t, tgt_p;
        int exp2 [4] = '{1, 3, 1, 3};
        int exp0 [8] = '{0, 1, 2, 3, 1, 2, 3, 1};

        record = 1'b0;
        for (int t = 0; t < NT; t++)
            for (int a = 0; a < PCN; a++) m_mem[t][a] = 0;
        rst = 1'b0;
        en_pc_net = 1'b0;
        conf_bus_in = '0;
        model_reset();
        #2;
        chk("reset_idx", thread_idx_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int t = 0; t < NT; t++)
            for (int a = 0; a < PCN; a++)
                tick(bw(3, SW, t, a, mem_init(t, a)), 1'b0);
        tick(bw(1, SW, 0, 3, 0), 1'b0);
        tick(bw(2, SW, 0, 1, 0), 1'b0);
        tick(bw(1, SW, 2, 1, 0), 1'b0);
        tick(bw(2, SW, 2, 0, 0), 1'b0);
        tick(bw(1, SW, 3, 1, 0), 1'b0);
        tick(bw(2, SW, 3, 3, 0), 1'b0);
        tick(bw(1, SW, 4, 3, 0), 1'b0);
        tick(bw(2, SW, 4, 0, 0), 1'b0);
        enable_all();

        record = 1'b1;
        run(80);
        record = 1'b0;
        chk("obs2_len_ok", 32'(obs2.size() >= 4), 1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("seq_t2_%0d", i), (i < obs2.size()) ? 32'(obs2[i]) : 'x, exp2[i]);
        chk("obs0_len_ok", 32'(obs0.size() >= 8), 1);
        for (int i = 0; i < 8; i++)
            chk($sformatf("seq_t0_%0d", i), (i < obs0.size()) ? 32'(obs0[i]) : 'x, exp0[i]);

        tick(bw(4, SW, 4, 0, 0), 1'b1);
        run(25);
        tick(bw(4, SW, 4, 0, 1), 1'b1);
        run(25);

        tick(bw(3, SW + 1, 2, 0, 2), 1'b1);
        tick(bw(1, SW, 7, 0, 0), 1'b1);
        tick(bw(4, SW, 200, 0, 0), 1'b1);
        tick(bw(5, SW + 1, 0, 0, 0), 1'b1);
        run(15);

        for (int i = 0; i < 10; i++) tick('0, 1'b0);
        run(15);

        tick(bw(1, SW, 0, 2, 0), 1'b1);
        run(20);

        tgt_t = (m_tidx + 1) % NT;
        tgt_p = m_pc[tgt_t];
        tick(bw(3, SW, tgt_t, tgt_p, (m_mem[tgt_t][tgt_p] + 1) % PCN), 1'b1);
        run(20);

        do_reset();
        tick(bw(1, SW, 0, 3, 0), 1'b0);
        tick(bw(2, SW, 0, 1, 0), 1'b0);
        enable_all();
        run(30);

        tick(bw(5, SW, 0, 0, 0), 1'b1);
        tick('0, 1'b1);
        chk("restart_idx", thread_idx_out, 0);
        run(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
